// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO controller: default geometry, thresholds and
// the error-cause encoding used by checkers.
package fifo_ctrl_pkg;

  localparam int FIFO_DATA_W    = 4;
  localparam int FIFO_ADDR_W    = 3;
  localparam int FIFO_AF_THRESH = 6;
  localparam int FIFO_AE_THRESH = 2;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_OVERFLOW  = 2'd1,
    ERR_UNDERFLOW = 2'd2,
    ERR_BOTH      = 2'd3
  } err_cause_e;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping ADDR_W-bit pointer with increment enable; wraps via natural overflow.
module fifo_ptr
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Sequencing controller for a dual-port FIFO RAM: strobes, pointers, occupancy,
// flags and a sticky error. FIFO_CTRL_THRESH_CFG_EN adds runtime threshold ports.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int AF_THRESH = FIFO_AF_THRESH,
  parameter int AE_THRESH = FIFO_AE_THRESH
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              error
`ifdef FIFO_CTRL_THRESH_CFG_EN
  ,
  input  logic [ADDR_W:0]   af_thresh,
  input  logic [ADDR_W:0]   ae_thresh
`endif
);

  localparam int DEPTH = fifo_depth(ADDR_W);
  localparam int CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;
  logic [CNT_W-1:0]  af_thr;
  logic [CNT_W-1:0]  ae_thr;

  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              valid_q;
  logic              error_q, error_d;

`ifdef FIFO_CTRL_THRESH_CFG_EN
  assign af_thr = af_thresh;
  assign ae_thr = ae_thresh;
`else
  assign af_thr = CNT_W'(AF_THRESH);
  assign ae_thr = CNT_W'(AE_THRESH);
`endif

  // A write while full is only legal when the same cycle also drains a word.
  always_comb begin
    pop_ok  = pop & ~empty_q;
    push_ok = push & (~full_q | pop_ok);

    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);

    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= af_thr);
    ae_d    = (count_d <= ae_thr);
    error_d = error_q | (push & ~push_ok) | (pop & empty_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      valid_q <= pop_ok;
      error_q <= error_d;
    end
  end

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk     (clk),
    .reset_L (reset_L),
    .inc_i   (push_ok),
    .ptr_o   (wr_ptr)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk     (clk),
    .reset_L (reset_L),
    .inc_i   (pop_ok),
    .ptr_o   (rd_ptr)
  );

  assign ram_we       = push_ok;
  assign ram_waddr    = wr_ptr;
  assign ram_wdata    = data_in;
  assign ram_re       = pop_ok;
  assign ram_raddr    = rd_ptr;
  assign data_out     = ram_rdata;
  assign valid_out    = valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign fifo_count   = count_q;
  assign error        = error_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed vector table, hand sequences and random traffic
// checked against a queue-based reference model; the RAM is modelled here.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       push = 1'b0;
  logic [3:0] data_in = '0;
  logic       pop = 1'b0;
  logic       ram_we, ram_re;
  logic [2:0] ram_waddr, ram_raddr;
  logic [3:0] ram_wdata, ram_rdata, data_out;
  logic       valid_out, full, empty, almost_full, almost_empty, error;
  logic [3:0] fifo_count;

  fifo_ctrl dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .ram_we       (ram_we),
    .ram_waddr    (ram_waddr),
    .ram_wdata    (ram_wdata),
    .ram_re       (ram_re),
    .ram_raddr    (ram_raddr),
    .ram_rdata    (ram_rdata),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_count   (fifo_count),
    .error        (error)
  );

  always #5 clk = ~clk;

  // External RAM: registered read, read-before-write on address collision.
  logic [3:0] mem [8];
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem[ram_raddr];
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_step  = 0;

  // Reference model: the FIFO is simply a queue of accepted words.
  int  mq[$];
  bit  m_known = 1'b0;
  bit  m_err = 1'b0;
  bit  m_vld = 1'b0;
  int  m_dout = 0;
  int  m_wp = 0;
  int  m_rp = 0;
  logic s_we, s_re;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, n_step);
    end
  endtask

  task automatic step(input bit rn, input bit p, input logic [3:0] d, input bit pp);
    bit pok, wok;
    int sz;
    err_cause_e cause;
    @(negedge clk);
    reset_L = rn; push = p; data_in = d; pop = pp;
    #1;
    sz  = mq.size();
    pok = pp && (sz > 0);
    wok = p && ((sz < 8) || pok);
    s_we = ram_we;
    s_re = ram_re;
    if (m_known) begin
      chk("ram_we", ram_we, wok);
      chk("ram_re", ram_re, pok);
      chk("ram_waddr", ram_waddr, m_wp);
      chk("ram_raddr", ram_raddr, m_rp);
      if (wok) chk("ram_wdata", ram_wdata, d);
    end
    @(posedge clk);
    #1;
    cause = ERR_NONE;
    if (!rn) begin
      mq.delete();
      m_err = 1'b0; m_vld = 1'b0; m_wp = 0; m_rp = 0; m_known = 1'b1;
    end else begin
      if (p && !wok && !(pp && sz == 0)) cause = ERR_OVERFLOW;
      else if (!(p && !wok) && pp && sz == 0) cause = ERR_UNDERFLOW;
      else if (p && !wok && pp && sz == 0) cause = ERR_BOTH;
      if (cause != ERR_NONE) m_err = 1'b1;
      m_vld = pok;
      if (pok) begin m_dout = mq.pop_front(); m_rp = (m_rp + 1) % 8; end
      if (wok) begin mq.push_back(int'(d)); m_wp = (m_wp + 1) % 8; end
    end
    if (m_known) begin
      chk("count", fifo_count, mq.size());
      chk("full", full, mq.size() == 8);
      chk("empty", empty, mq.size() == 0);
      chk("almost_full", almost_full, mq.size() >= 6);
      chk("almost_empty", almost_empty, mq.size() <= 2);
      chk("error", error, m_err);
      chk("valid_out", valid_out, m_vld);
      if (m_vld) chk("data_out", data_out, m_dout);
    end
    $display("[TB] step %0d rst_n=%0b push=%0b din=%0h pop=%0b -> cnt=%0d vld=%0b dout=%0h err=%0b cause=%s",
             n_step, rn, p, d, pp, fifo_count, valid_out, data_out, error, cause.name());
    n_step++;
  endtask

  typedef struct {
    bit rn; bit push; logic [3:0] din; bit pop;
    bit we; bit re; int cnt;
    bit full; bit empty; bit af; bit ae; bit err; bit vld; int dout;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rn, bit p, int d, bit pp, bit we, bit re, int cnt,
                              bit fu, bit em, bit af, bit ae, bit er, bit vl, int dout);
    vec_t v;
    v.rn = rn; v.push = p; v.din = 4'(d); v.pop = pp; v.we = we; v.re = re; v.cnt = cnt;
    v.full = fu; v.empty = em; v.af = af; v.ae = ae; v.err = er; v.vld = vl; v.dout = dout;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              rn p  d  pp we re cnt fu em af ae er vl dout
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2, 0, 1, 0, 2, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 4, 0, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 6, 0, 1, 0, 6, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 7, 0, 1, 0, 7, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8, 0, 1, 0, 8, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 9, 1, 1, 1, 8, 1, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 10, 0, 0, 0, 8, 1, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8, 1, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 7, 0, 0, 1, 0, 1, 1, 2));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 6, 0, 0, 1, 0, 1, 1, 3));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 5, 0, 0, 0, 0, 1, 1, 4));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 4, 0, 0, 0, 0, 1, 1, 5));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 3, 0, 0, 0, 0, 1, 1, 6));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 2, 0, 0, 0, 1, 1, 1, 7));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1, 1, 8));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 9));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 5, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 5));

    foreach (tbl[i]) begin
      step(tbl[i].rn, tbl[i].push, tbl[i].din, tbl[i].pop);
      if (i > 0) begin
        chk("tbl_we", s_we, tbl[i].we);
        chk("tbl_re", s_re, tbl[i].re);
      end
      chk("tbl_count", fifo_count, tbl[i].cnt);
      chk("tbl_full", full, tbl[i].full);
      chk("tbl_empty", empty, tbl[i].empty);
      chk("tbl_af", almost_full, tbl[i].af);
      chk("tbl_ae", almost_empty, tbl[i].ae);
      chk("tbl_error", error, tbl[i].err);
      chk("tbl_valid", valid_out, tbl[i].vld);
      if (tbl[i].vld) chk("tbl_data", data_out, tbl[i].dout);
    end

    // Overflow stays sticky through idle cycles.
    step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 4'($urandom_range(0, 15)), 0);
    step(1, 1, 4'hF, 0);
    chk("ovf_we", s_we, 1'b0);
    chk("ovf_count", fifo_count, 8);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      chk("ovf_sticky", error, 1'b1);
    end

    // Interleaved push/pop pairs walk both pointers around the ring.
    step(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      logic [3:0] d;
      d = 4'($urandom_range(0, 15));
      step(1, 1, d, 0);
      step(1, 0, 0, 1);
      chk("wrap_data", data_out, d);
      chk("wrap_valid", valid_out, 1'b1);
    end

    // Mid-stream reset also cancels a pop issued in the reset cycle.
    for (int i = 0; i < 3; i++) step(1, 1, 4'(i + 1), 0);
    step(1, 1, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_error", error, 1'b0);
    chk("rst_valid", valid_out, 1'b0);

    // Random traffic in push-heavy and pop-heavy phases.
    for (int ph = 0; ph < 8; ph++) begin
      int bias;
      bias = (ph % 2 == 0) ? 75 : 25;
      for (int i = 0; i < 40; i++) begin
        bit rn, p, pp;
        rn = ($urandom_range(0, 59) != 0);
        p  = ($urandom_range(0, 99) < bias);
        pp = ($urandom_range(0, 99) < (100 - bias));
        step(rn, p, 4'($urandom_range(0, 15)), pp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
